// File: rtl/video_ip_pkg.sv
// Shared definitions for the video IP output path.
// Pixel format, default frame geometry and framing states.
package video_ip_pkg;

    localparam int PIXEL_W              = 16;
    localparam int FRAME_PIXELS_DEFAULT = 76800;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } frame_state_e;

endpackage

// File: rtl/avalon_st_source_interface_if.sv
// Avalon-ST beat bundle: valid/ready handshake plus data and
// packet delimiters. master drives beats, slave receives them.
interface avalon_st_source_interface_if
    import video_ip_pkg::*;
#(
    parameter int DATA_W = PIXEL_W
) ();

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;

    modport master (
        output valid,
        output data,
        output sop,
        output eop,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  sop,
        input  eop,
        output ready
    );

endinterface

// File: rtl/avalon_st_skid_buffer.sv
// Two-entry skid buffer: main output register plus one overflow
// register, so in_ready depends only on flop state.
module avalon_st_skid_buffer #(
    parameter int PAYLOAD_W = 18
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload
);

    logic                 main_valid_q, main_valid_d;
    logic [PAYLOAD_W-1:0] main_data_q,  main_data_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [PAYLOAD_W-1:0] skid_data_q,  skid_data_d;
    logic                 accept;
    logic                 main_free;

    assign in_ready    = !skid_valid_q;
    assign out_valid   = main_valid_q;
    assign out_payload = main_data_q;
    assign accept      = in_valid && !skid_valid_q;
    assign main_free   = !main_valid_q || out_ready;

    // Refill main from skid first to keep order; overflow to skid on stall.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (main_free) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_data_d = in_payload;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_payload;
        end
    end

    // Buffer state; reset discards every held beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/avalon_st_source_interface.sv
// Output Avalon-ST source: framing monitor, pixel counter and
// sticky error flags in front of a registered skid buffer.
module avalon_st_source_interface
    import video_ip_pkg::*;
#(
    parameter int DATA_W       = PIXEL_W,
    parameter int FRAME_PIXELS = FRAME_PIXELS_DEFAULT,
    parameter int COUNT_W      = 17
) (
    input  logic                         clk,
    input  logic                         reset_n,
    avalon_st_source_interface_if.slave  in_st,
    avalon_st_source_interface_if.master out_st,
    input  logic                         clear_errors,
    output logic                         frame_done,
    output logic [COUNT_W-1:0]           pixel_count,
    output logic                         err_orphan,
    output logic                         err_missing_eop,
    output logic                         err_length
);

    localparam int                 PAYLOAD_W = DATA_W + 2;
    localparam logic [COUNT_W-1:0] FRAME_LEN = COUNT_W'(FRAME_PIXELS);
    localparam logic [COUNT_W-1:0] ONE       = COUNT_W'(1);

    frame_state_e         state_q, state_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [COUNT_W-1:0]   count_inc;
    logic                 err_orphan_q, err_orphan_d;
    logic                 err_missing_eop_q, err_missing_eop_d;
    logic                 err_length_q, err_length_d;
    logic                 frame_done_q, frame_done_d;
    logic                 set_orphan, set_missing, set_length;
    logic                 accept;
    logic                 forward;
    logic [PAYLOAD_W-1:0] out_payload;

    assign accept    = in_st.valid && in_st.ready;
    // Orphan beats are consumed without being handed to the buffer.
    assign forward   = in_st.sop || (state_q == IN_PKT);
    assign count_inc = (count_q == '1) ? count_q : count_q + ONE;

    avalon_st_skid_buffer #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_st.valid && forward),
        .in_ready    (in_st.ready),
        .in_payload  ({in_st.sop, in_st.eop, in_st.data}),
        .out_valid   (out_st.valid),
        .out_ready   (out_st.ready),
        .out_payload (out_payload)
    );

    assign out_st.sop  = out_payload[PAYLOAD_W-1];
    assign out_st.eop  = out_payload[PAYLOAD_W-2];
    assign out_st.data = out_payload[DATA_W-1:0];

    // Framing next-state, pixel counter and error set conditions.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        set_orphan  = 1'b0;
        set_missing = 1'b0;
        set_length  = 1'b0;
        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (in_st.sop) begin
                        count_d    = ONE;
                        state_d    = in_st.eop ? IDLE : IN_PKT;
                        set_length = in_st.eop && (ONE != FRAME_LEN);
                    end else begin
                        set_orphan = 1'b1;
                    end
                end
                IN_PKT: begin
                    if (in_st.sop) begin
                        set_missing = 1'b1;
                        count_d     = ONE;
                        if (in_st.eop) begin
                            state_d    = IDLE;
                            set_length = (ONE != FRAME_LEN);
                        end
                    end else begin
                        count_d = count_inc;
                        if (in_st.eop) begin
                            state_d    = IDLE;
                            set_length = (count_inc != FRAME_LEN);
                        end
                    end
                end
            endcase
        end
    end

    // Sticky flags: a new set outranks a simultaneous clear.
    always_comb begin
        err_orphan_d      = (err_orphan_q && !clear_errors) || set_orphan;
        err_missing_eop_d = (err_missing_eop_q && !clear_errors) || set_missing;
        err_length_d      = (err_length_q && !clear_errors) || set_length;
        frame_done_d      = out_st.valid && out_st.ready && out_st.eop;
    end

    // Framing state, counter, flags and the frame_done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            count_q           <= '0;
            err_orphan_q      <= 1'b0;
            err_missing_eop_q <= 1'b0;
            err_length_q      <= 1'b0;
            frame_done_q      <= 1'b0;
        end else begin
            state_q           <= state_d;
            count_q           <= count_d;
            err_orphan_q      <= err_orphan_d;
            err_missing_eop_q <= err_missing_eop_d;
            err_length_q      <= err_length_d;
            frame_done_q      <= frame_done_d;
        end
    end

    assign pixel_count     = count_q;
    assign err_orphan      = err_orphan_q;
    assign err_missing_eop = err_missing_eop_q;
    assign err_length      = err_length_q;
    assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_avalon_st_source_interface.sv
// Scoreboard bench for the Avalon-ST output source: forwarded beats
// are queued on accept and matched against downstream transfers.
module tb_avalon_st_source_interface;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_errors = 1'b0;
    logic        frame_done;
    logic [16:0] pixel_count;
    logic        err_orphan;
    logic        err_missing_eop;
    logic        err_length;

    avalon_st_source_interface_if #(.DATA_W(16)) in_if ();
    avalon_st_source_interface_if #(.DATA_W(16)) out_if ();

    avalon_st_source_interface dut (
        .clk             (clk),
        .reset_n         (rst_n),
        .in_st           (in_if),
        .out_st          (out_if),
        .clear_errors    (clear_errors),
        .frame_done      (frame_done),
        .pixel_count     (pixel_count),
        .err_orphan      (err_orphan),
        .err_missing_eop (err_missing_eop),
        .err_length      (err_length)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          occ = 0;
    int          fd_count = 0;
    int          xfer_count = 0;
    int          stall_cycles = 0;
    int          ready_mode = 1;
    logic        drv_fwd = 1'b0;
    logic        fd_exp = 1'b0;
    logic        prev_stall = 1'b0;
    logic [17:0] prev_payload = '0;
    logic [17:0] exp_q[$];

    initial begin
        in_if.valid = 1'b0;
        in_if.data  = '0;
        in_if.sop   = 1'b0;
        in_if.eop   = 1'b0;
    end

    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       out_if.ready = 1'b0;
            1:       out_if.ready = 1'b1;
            default: out_if.ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        logic        xfer;
        logic        fwd;
        logic        exp_rdy;
        logic [17:0] cur;
        logic [17:0] exp;
        if (!rst_n) begin
            exp_q.delete();
            occ        = 0;
            fd_exp     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            cur     = {out_if.sop, out_if.eop, out_if.data};
            exp_rdy = (occ < 2);
            tests++;
            if (in_if.ready !== exp_rdy) begin
                fails++;
                $display("FAIL in_ready: got %b required %b", in_if.ready, exp_rdy);
            end
            tests++;
            if (frame_done !== fd_exp) begin
                fails++;
                $display("FAIL frame_done: got %b required %b", frame_done, fd_exp);
            end
            if (frame_done === 1'b1) fd_count++;
            if (prev_stall) begin
                tests++;
                if (out_if.valid !== 1'b1 || cur !== prev_payload) begin
                    fails++;
                    $display("FAIL stall_stable: got v=%b %h required v=1 %h",
                             out_if.valid, cur, prev_payload);
                end
            end
            xfer = out_if.valid && out_if.ready;
            fwd  = in_if.valid && in_if.ready && drv_fwd;
            if (xfer) begin
                xfer_count++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat: got %h required none", cur);
                end else begin
                    exp = exp_q.pop_front();
                    if (cur !== exp) begin
                        fails++;
                        $display("FAIL beat_order: got %h required %h", cur, exp);
                    end
                end
            end
            occ          = occ + int'(fwd) - int'(xfer);
            fd_exp       = xfer && out_if.eop;
            prev_stall   = out_if.valid && !out_if.ready;
            prev_payload = cur;
        end
    end

    task automatic send_beat(input logic [15:0] d, input logic s,
                             input logic e, input logic f);
        logic acc;
        int   n;
        in_if.valid = 1'b1;
        in_if.data  = d;
        in_if.sop   = s;
        in_if.eop   = e;
        drv_fwd     = f;
        n = 0;
        forever begin
            @(negedge clk);
            acc = in_if.ready;
            if (acc && f) exp_q.push_back({s, e, d});
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            stall_cycles++;
            if (n > 2000) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: in_ready %b required 1", in_if.ready);
                break;
            end
        end
    endtask

    task automatic idle();
        in_if.valid = 1'b0;
        drv_fwd     = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && out_if.valid === 1'b0) break;
            n++;
            if (n > 3000) break;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d beats outstanding required 0", tag, exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_errs();
        clear_errors = 1'b1;
        @(posedge clk);
        #1;
        clear_errors = 1'b0;
    endtask

    task automatic check_errs(input string tag, input logic [2:0] exp);
        tests++;
        if ({err_orphan, err_missing_eop, err_length} !== exp) begin
            fails++;
            $display("FAIL %s_errs: got %b required %b", tag,
                     {err_orphan, err_missing_eop, err_length}, exp);
        end
    endtask

    task automatic check_count(input string tag, input logic [16:0] exp);
        tests++;
        if (pixel_count !== exp) begin
            fails++;
            $display("FAIL %s_count: got %0d required %0d", tag, pixel_count, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({out_if.valid, out_if.sop, out_if.eop, out_if.data} !== 19'd0) begin
            fails++;
            $display("FAIL reset_out: got %b%b%b %h required 0",
                     out_if.valid, out_if.sop, out_if.eop, out_if.data);
        end
        tests++;
        if (in_if.ready !== 1'b1 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: got rdy=%b fd=%b required 1 0",
                     in_if.ready, frame_done);
        end
        check_count("reset", 17'd0);
        check_errs("reset", 3'b000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_frame();
        ready_mode = 1;
        @(posedge clk);
        #1;
        fd_count = 0;
        stall_cycles = 0;
        xfer_count = 0;
        for (int i = 0; i < 76800; i++) begin
            send_beat(16'(i), i == 0, i == 76799, 1'b1);
        end
        idle();
        check_count("full", 17'd76800);
        wait_drain("full");
        tests++;
        if (fd_count != 1 || xfer_count != 76800 || stall_cycles != 0) begin
            fails++;
            $display("FAIL full_frame: got fd=%0d xfers=%0d stalls=%0d required 1 76800 0",
                     fd_count, xfer_count, stall_cycles);
        end
        check_errs("full", 3'b000);
    endtask

    task automatic test_burst_random();
        ready_mode = 2;
        xfer_count = 0;
        for (int b = 0; b < 3; b++) begin
            for (int k = 1; k <= 8; k++) begin
                send_beat(16'(k), k == 1, k == 8, 1'b1);
            end
        end
        idle();
        wait_drain("burst");
        ready_mode = 1;
        tests++;
        if (xfer_count != 24) begin
            fails++;
            $display("FAIL burst_xfers: got %0d required 24", xfer_count);
        end
        check_count("burst", 17'd8);
    endtask

    task automatic test_orphan();
        clear_errs();
        check_errs("orphan_pre", 3'b000);
        send_beat(16'hDEA0, 1'b0, 1'b0, 1'b0);
        send_beat(16'hDEA1, 1'b0, 1'b0, 1'b0);
        clear_errors = 1'b1;
        send_beat(16'hDEA2, 1'b0, 1'b0, 1'b0);
        clear_errors = 1'b0;
        idle();
        check_errs("orphan_setwins", 3'b100);
        fd_count = 0;
        for (int k = 0; k < 5; k++) begin
            send_beat(16'h0100 + 16'(k), k == 0, k == 4, 1'b1);
        end
        idle();
        wait_drain("orphan");
        check_errs("orphan_post", 3'b101);
        tests++;
        if (fd_count != 1) begin
            fails++;
            $display("FAIL orphan_frame_done: got %0d required 1", fd_count);
        end
    endtask

    task automatic test_missing_eop();
        clear_errs();
        for (int k = 0; k < 100; k++) begin
            send_beat(16'h2000 + 16'(k), k == 0, 1'b0, 1'b1);
        end
        check_count("pre_sop", 17'd100);
        send_beat(16'h3000, 1'b1, 1'b0, 1'b1);
        check_errs("missing_eop", 3'b010);
        check_count("restart", 17'd1);
        send_beat(16'h3001, 1'b0, 1'b1, 1'b1);
        idle();
        wait_drain("missing");
        check_count("missing_end", 17'd2);
    endtask

    task automatic test_length_and_clear();
        clear_errs();
        fd_count = 0;
        for (int k = 0; k < 500; k++) begin
            send_beat(16'h4000 + 16'(k), k == 0, k == 499, 1'b1);
        end
        idle();
        check_count("length", 17'd500);
        check_errs("length", 3'b001);
        wait_drain("length");
        tests++;
        if (fd_count != 1) begin
            fails++;
            $display("FAIL length_frame_done: got %0d required 1", fd_count);
        end
        clear_errs();
        check_errs("cleared", 3'b000);
    endtask

    task automatic test_reset_midframe();
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        send_beat(16'hA000, 1'b1, 1'b0, 1'b1);
        send_beat(16'hA001, 1'b0, 1'b0, 1'b1);
        in_if.valid = 1'b1;
        in_if.data  = 16'hA002;
        in_if.sop   = 1'b0;
        in_if.eop   = 1'b0;
        tests++;
        if (in_if.ready !== 1'b0) begin
            fails++;
            $display("FAIL skid_full: in_ready %b required 0", in_if.ready);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_if.valid !== 1'b0 || in_if.ready !== 1'b1) begin
            fails++;
            $display("FAIL async_reset: got v=%b rdy=%b required 0 1",
                     out_if.valid, in_if.ready);
        end
        check_count("async_reset", 17'd0);
        idle();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            send_beat(16'hB000 + 16'(k), k == 0, 1'b0, 1'b1);
        end
        idle();
        wait_drain("post_reset");
        check_errs("post_reset", 3'b000);
        check_count("post_reset", 17'd4);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_burst_random();
        test_orphan();
        test_missing_eop();
        test_length_and_clear();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
